// File: rtl/avaliador_cor_pkg.sv
// avaliador_cor_pkg: state encoding and colour-window helper for the colour evaluator
package avaliador_cor_pkg;
   typedef enum logic [2:0] {OCIOSO, DESCARTANDO, ACUMULANDO, DECIDINDO, AGUARDA_SAIDA} tipo_estado;
   function automatic logic dentro_janela(input int unsigned valor, input int unsigned vmin, input int unsigned vmax);
      return (valor >= vmin) && (valor <= vmax);
   endfunction
endpackage

// File: rtl/avaliador_cor_acumulador.sv
// acumulador_canal: per-channel sample accumulator with truncating power-of-two average
// ports: clk, rst (sync, active-high), limpa (clear), soma (add amostra), amostra (sample), media (acc >> LOG2_N)
module acumulador_canal #(
   parameter int LARGURA = 8,
   parameter int LOG2_N  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               limpa,
   input  logic               soma,
   input  logic [LARGURA-1:0] amostra,
   output logic [LARGURA-1:0] media
);
   logic [LARGURA+LOG2_N-1:0] acc;
   always_ff @(posedge clk)
      if (rst || limpa) acc <= '0;
      else if (soma) acc <= acc + {{LOG2_N{1'b0}}, amostra};
   assign media = acc[LARGURA+LOG2_N-1:LOG2_N];
endmodule

// File: rtl/avaliador_cor.sv
// avaliador_cor: averages RGB samples per piece and emits a one-cycle pass/fail verdict
// ports: clk, rst (sync, active-high), presenca (piece present), amostra_valida/r/g/b (sample),
//        rgb (verdict, held), rgb_valido (verdict pulse), ocupado (measurement in progress)
module avaliador_cor
   import avaliador_cor_pkg::*;
#(
   parameter int LARGURA  = 8,
   parameter int LOG2_N   = 2,
   parameter int DESCARTE = 2,
   parameter int R_MIN    = 100,
   parameter int R_MAX    = 200,
   parameter int G_MIN    = 50,
   parameter int G_MAX    = 150,
   parameter int B_MIN    = 0,
   parameter int B_MAX    = 80
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               presenca,
   input  logic               amostra_valida,
   input  logic [LARGURA-1:0] r,
   input  logic [LARGURA-1:0] g,
   input  logic [LARGURA-1:0] b,
   output logic               rgb,
   output logic               rgb_valido,
   output logic               ocupado
);
   localparam int N    = 1 << LOG2_N;
   localparam int CMAX = DESCARTE > N ? DESCARTE : N;
   localparam int CW   = $clog2(CMAX + 1);
   tipo_estado estado, prox;
   logic [CW-1:0] cnt, cnt_prox;
   logic limpa, soma, decide, veredito;
   logic [LARGURA-1:0] media_r, media_g, media_b;
   acumulador_canal #(.LARGURA(LARGURA), .LOG2_N(LOG2_N)) u_r (.clk(clk), .rst(rst), .limpa(limpa), .soma(soma), .amostra(r), .media(media_r));
   acumulador_canal #(.LARGURA(LARGURA), .LOG2_N(LOG2_N)) u_g (.clk(clk), .rst(rst), .limpa(limpa), .soma(soma), .amostra(g), .media(media_g));
   acumulador_canal #(.LARGURA(LARGURA), .LOG2_N(LOG2_N)) u_b (.clk(clk), .rst(rst), .limpa(limpa), .soma(soma), .amostra(b), .media(media_b));
   assign veredito = dentro_janela(media_r, R_MIN, R_MAX) && dentro_janela(media_g, G_MIN, G_MAX) && dentro_janela(media_b, B_MIN, B_MAX);
   always_ff @(posedge clk)
      if (rst) begin
         estado     <= OCIOSO;
         cnt        <= '0;
         rgb        <= 1'b0;
         rgb_valido <= 1'b0;
         ocupado    <= 1'b0;
      end else begin
         estado     <= prox;
         cnt        <= cnt_prox;
         rgb        <= decide ? veredito : rgb;
         rgb_valido <= decide;
         ocupado    <= prox == DESCARTANDO || prox == ACUMULANDO || prox == DECIDINDO;
      end
   // losing presence mid-measurement aborts before any sample in that cycle is used
   always_comb begin
      prox     = estado;
      cnt_prox = cnt;
      limpa    = 1'b0;
      soma     = 1'b0;
      decide   = 1'b0;
      case (estado)
         OCIOSO: begin
            limpa    = 1'b1;
            cnt_prox = '0;
            prox     = !presenca ? OCIOSO : DESCARTE == 0 ? ACUMULANDO : DESCARTANDO;
         end
         DESCARTANDO:
            if (!presenca) begin
               prox     = OCIOSO;
               limpa    = 1'b1;
               cnt_prox = '0;
            end else if (amostra_valida) begin
               prox     = cnt == CW'(DESCARTE - 1) ? ACUMULANDO : DESCARTANDO;
               cnt_prox = cnt == CW'(DESCARTE - 1) ? '0 : cnt + 1'b1;
            end
         ACUMULANDO:
            if (!presenca) begin
               prox     = OCIOSO;
               limpa    = 1'b1;
               cnt_prox = '0;
            end else if (amostra_valida) begin
               soma     = 1'b1;
               prox     = cnt == CW'(N - 1) ? DECIDINDO : ACUMULANDO;
               cnt_prox = cnt == CW'(N - 1) ? '0 : cnt + 1'b1;
            end
         DECIDINDO: begin
            prox   = presenca ? AGUARDA_SAIDA : OCIOSO;
            limpa  = !presenca;
            decide = presenca;
         end
         AGUARDA_SAIDA: prox = presenca ? AGUARDA_SAIDA : OCIOSO;
         default: prox = OCIOSO;
      endcase
   end
endmodule

// File: tb/tb_avaliador_cor.sv
// tb_avaliador_cor: directed self-checking bench for the colour evaluator
module tb_avaliador_cor;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic presenca = 1'b0;
   logic amostra_valida = 1'b0;
   logic [7:0] r = '0, g = '0, b = '0;
   logic rgb, rgb_valido, ocupado;
   int testes = 0;
   int falhas = 0;
   int pulsos = 0;
   int marca;
   avaliador_cor dut (
      .clk(clk), .rst(rst), .presenca(presenca), .amostra_valida(amostra_valida),
      .r(r), .g(g), .b(b), .rgb(rgb), .rgb_valido(rgb_valido), .ocupado(ocupado)
   );
   always #5 clk = ~clk;
   always @(negedge clk) if (rgb_valido) pulsos <= pulsos + 1;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input int obs, input int exp);
      testes++;
      assert (obs === exp) else begin
         falhas++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic amostra(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
      amostra_valida = 1'b1;
      r = rr;
      g = gg;
      b = bb;
      tick();
      amostra_valida = 1'b0;
   endtask
   task automatic medir(input logic [7:0] r0, r1, r2, r3, gg, bb);
      presenca = 1'b1;
      tick();
      amostra(8'd255, 8'd255, 8'd255);
      amostra(8'd255, 8'd255, 8'd255);
      amostra(r0, gg, bb);
      amostra(r1, gg, bb);
      tick();
      amostra(r2, gg, bb);
      amostra(r3, gg, bb);
   endtask
   task automatic veredito(input string tag, input int exp);
      chk({tag, "_decidindo_valido"}, int'(rgb_valido), 0);
      chk({tag, "_decidindo_ocupado"}, int'(ocupado), 1);
      tick();
      chk({tag, "_valido"}, int'(rgb_valido), 1);
      chk({tag, "_rgb"}, int'(rgb), exp);
      chk({tag, "_ocupado_fim"}, int'(ocupado), 0);
      tick();
      chk({tag, "_valido_pulso_unico"}, int'(rgb_valido), 0);
      presenca = 1'b0;
      tick();
   endtask
   initial begin
      tick();
      rst = 1'b0;
      chk("reset_rgb", int'(rgb), 0);
      chk("reset_valido", int'(rgb_valido), 0);
      chk("reset_ocupado", int'(ocupado), 0);
      presenca = 1'b1;
      tick();
      chk("presenca_ocupado", int'(ocupado), 1);
      presenca = 1'b0;
      tick();
      chk("ocioso_solto", int'(ocupado), 0);
      medir(8'd120, 8'd130, 8'd140, 8'd150, 8'd100, 8'd40);
      veredito("aprova", 1);
      medir(8'd120, 8'd130, 8'd140, 8'd150, 8'd100, 8'd90);
      veredito("rejeita_azul", 0);
      medir(8'd100, 8'd100, 8'd100, 8'd100, 8'd50, 8'd80);
      veredito("limite_inclusivo", 1);
      marca = pulsos;
      presenca = 1'b1;
      tick();
      amostra(8'd255, 8'd255, 8'd255);
      amostra(8'd255, 8'd255, 8'd255);
      amostra(8'd255, 8'd255, 8'd255);
      amostra(8'd255, 8'd255, 8'd255);
      presenca = 1'b0;
      amostra(8'd255, 8'd255, 8'd255);
      chk("aborto_ocupado", int'(ocupado), 0);
      chk("aborto_valido", int'(rgb_valido), 0);
      tick();
      tick();
      tick();
      chk("aborto_rgb_mantido", int'(rgb), 1);
      chk("aborto_sem_pulso", pulsos - marca, 0);
      medir(8'd99, 8'd100, 8'd100, 8'd100, 8'd50, 8'd80);
      veredito("truncamento", 0);
      marca = pulsos;
      medir(8'd120, 8'd130, 8'd140, 8'd150, 8'd100, 8'd90);
      tick();
      tick();
      for (int i = 0; i < 40; i++) amostra(8'd150, 8'd100, 8'd40);
      chk("uma_peca_um_pulso", pulsos - marca, 1);
      chk("uma_peca_rgb", int'(rgb), 0);
      presenca = 1'b0;
      tick();
      medir(8'd120, 8'd130, 8'd140, 8'd150, 8'd100, 8'd40);
      veredito("segunda_medida", 1);
      chk("segunda_medida_pulsos", pulsos - marca, 2);
      presenca = 1'b1;
      tick();
      amostra(8'd255, 8'd255, 8'd255);
      amostra(8'd255, 8'd255, 8'd255);
      amostra(8'd255, 8'd255, 8'd255);
      amostra(8'd255, 8'd255, 8'd255);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_meio_rgb", int'(rgb), 0);
      chk("rst_meio_valido", int'(rgb_valido), 0);
      chk("rst_meio_ocupado", int'(ocupado), 0);
      presenca = 1'b0;
      tick();
      medir(8'd200, 8'd200, 8'd200, 8'd200, 8'd150, 8'd0);
      veredito("pos_reset", 1);
      $display("[TB] %0d tests run, %0d failed", testes, falhas);
      $finish;
   end
endmodule
